edge_detector_mealy: RTL and testbench
======================================

# edge_detector_mealy

Multi-lane Mealy-style edge detector that converts level inputs into single-cycle tick pulses. Each lane has a two-state FSM tracking the last sampled level. Outputs are combinational in the current state and the current input, so a tick asserts in the same cycle the input rises. It sits between slow or asynchronous level sources (buttons, status flags, handshake lines) and synchronous logic that needs one-cycle event strobes.

## Interface
- WIDTH, 1: number of independent lanes (1..64).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-low (rst=0 resets on the next clk edge).
- lvl  input  WIDTH  level inputs, one per lane.
- edge_tick  output  WIDTH  per-lane rising-edge tick (0→1).
- fall_tick  output  WIDTH  per-lane falling-edge tick (1→0).
- any_tick  output  1  OR-reduction of edge_tick|fall_tick over all lanes.

## Operation
- Per-lane FSM states: ZERO (last sampled level 0) and ONE (last sampled level 1).
- Transitions at posedge clk with rst=1:
  - ZERO→ONE when lvl=1.
  - ONE→ZERO when lvl=0.
  - Otherwise hold.
- Mealy outputs, combinational, per lane:
  - edge_tick = rst & (state==ZERO) & lvl.
  - fall_tick = rst & (state==ONE) & ~lvl.
- Reset: at posedge clk with rst=0, every lane goes to ZERO. While rst=0, edge_tick, fall_tick and any_tick are forced 0 regardless of lvl.
- After reset release, a lane whose lvl is already 1 produces one edge_tick in the first cycle with rst=1.
- A held-high level produces exactly one edge_tick. A held-low level produces none, apart from the single fall_tick when it drops.
- Lanes are fully independent. Simultaneous edges on several lanes assert the corresponding bits in the same cycle.
- A one-cycle pulse (0,1,0 on consecutive samples) yields edge_tick in the cycle it is high and fall_tick in the next cycle.
- Asserting reset mid-operation immediately masks all ticks and clears state on that edge.

## Timing
- Latency: 0 cycles from lvl to tick; the tick is valid before the same posedge that updates the state.
- Tick width: exactly one clk cycle, provided lvl is stable around the edge.
- lvl must meet setup/hold to clk unless EDGE_DETECTOR_MEALY_SYNC_EN is defined.
- No handshake; consumers sample ticks at posedge clk.
- Outputs may glitch within a cycle as lvl changes. Downstream logic samples them only synchronously.

## Configuration
- EDGE_DETECTOR_MEALY_SYNC_EN defined:
  - A two-flop synchronizer per lane is inserted on lvl.
  - The FSM and output equations use the synchronized level, so ticks become glitch-free.
  - Latency becomes 2 cycles from lvl change to tick.
  - Synchronizer flops reset to 0 with rst.
- Not defined: lvl feeds the FSM directly with 0-cycle latency, as described above.

## Structure
- Shared package edge_detector_pkg:
  - state_t enum {ZERO, ONE}.
  - MAX_WIDTH=64 constant.
- Sub-module edge_lane: one lane containing the FSM, the optional synchronizer and the two tick outputs.
- Top module: generates WIDTH edge_lane instances and the any_tick reduction.
- Elaboration check: WIDTH must be in 1..MAX_WIDTH.

## Test plan
- Reset behaviour (WIDTH=1): hold rst=0 with lvl=1 for 2 cycles → all ticks 0. Release rst with lvl=1 → edge_tick=1 for one cycle, then 0.
- Sustained high: after reset with lvl=0 for 5 cycles, raise lvl and hold 5 cycles → edge_tick=1 exactly in the cycle of the rise. Dropping lvl → fall_tick=1 for one cycle.
- One-cycle pulse: lvl sequence 0,1,0 → edge_tick in cycle 2 and fall_tick in cycle 3, each high for exactly one cycle.
- Low gap: lvl 1,0,0,1 → fall_tick in cycle 2 and edge_tick in cycle 4.
- Reset mid-operation: lvl=1 in state ONE, then rst=0 with lvl=0 → no fall_tick. After rst=1 with lvl=0 for 30 time units → no ticks.
- Multi-lane (WIDTH=4): lvl 4'b0000→4'b0101 → edge_tick=4'b0101 and any_tick=1 for one cycle. Then 4'b0101→4'b0011 → edge_tick=4'b0010, fall_tick=4'b0100.

Source files
------------

// File: rtl/edge_detector_pkg.sv
// Shared types and limits for the multi-lane Mealy edge detector.
package edge_detector_pkg;

    typedef enum logic {
        ZERO = 1'b0,
        ONE  = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/edge_lane.sv
// One edge-detector lane: two-state FSM plus Mealy tick outputs.
// Defining EDGE_DETECTOR_MEALY_SYNC_EN puts a two-flop synchronizer in front of the FSM.
module edge_lane
    import edge_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic edge_tick,
    output logic fall_tick
);

    logic   lvl_s;
    state_t state_q;
    state_t state_d;

`ifdef EDGE_DETECTOR_MEALY_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    always_comb begin
        sync1_d = lvl;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign lvl_s = sync2_q;
`else
    assign lvl_s = lvl;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ZERO:    if (lvl_s)  state_d = ONE;
            ONE:     if (!lvl_s) state_d = ZERO;
            default: state_d = ZERO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ZERO;
        end else begin
            state_q <= state_d;
        end
    end

    // Ticks depend on the live level, so they appear in the same cycle as the change.
    assign edge_tick = rst & (state_q == ZERO) &  lvl_s;
    assign fall_tick = rst & (state_q == ONE)  & ~lvl_s;

endmodule

// File: rtl/edge_detector_mealy.sv
// Multi-lane Mealy edge detector: WIDTH independent edge_lane instances plus an any-tick OR.
// Optional synchronizer per lane is enabled with EDGE_DETECTOR_MEALY_SYNC_EN.
module edge_detector_mealy
    import edge_detector_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lvl,
    output logic [WIDTH-1:0] edge_tick,
    output logic [WIDTH-1:0] fall_tick,
    output logic             any_tick
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
            $error("edge_detector_mealy: WIDTH must be in 1..%0d", MAX_WIDTH);
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            edge_lane u_lane (
                .clk       (clk),
                .rst       (rst),
                .lvl       (lvl[i]),
                .edge_tick (edge_tick[i]),
                .fall_tick (fall_tick[i])
            );
        end
    endgenerate

    assign any_tick = |(edge_tick | fall_tick);

endmodule

// File: tb/tb_edge_detector_mealy.sv
// Bench for edge_detector_mealy (WIDTH=4): directed vectors with literal expectations,
// plus a per-cycle comparison against a last-sampled-level model.
module tb_edge_detector_mealy;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] edge_tick;
    logic [WIDTH-1:0] fall_tick;
    logic             any_tick;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    edge_detector_mealy #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .lvl       (lvl),
        .edge_tick (edge_tick),
        .fall_tick (fall_tick),
        .any_tick  (any_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a tick is the difference between the live level and the level seen at the last edge.
    logic [WIDTH-1:0] prev_lvl = '0;

    initial begin
        logic [WIDTH-1:0] exp_edge;
        logic [WIDTH-1:0] exp_fall;
        logic             exp_any;
        forever begin
            @(negedge clk);
            #4;
            if (run) begin
                exp_edge = rst ? (lvl & ~prev_lvl) : '0;
                exp_fall = rst ? (~lvl & prev_lvl) : '0;
                exp_any  = |(exp_edge | exp_fall);
                checks++;
                if (edge_tick !== exp_edge) begin
                    errors++;
                    $display("[TB] FAIL model_edge t=%0t got %b want %b", $time, edge_tick, exp_edge);
                end
                checks++;
                if (fall_tick !== exp_fall) begin
                    errors++;
                    $display("[TB] FAIL model_fall t=%0t got %b want %b", $time, fall_tick, exp_fall);
                end
                checks++;
                if (any_tick !== exp_any) begin
                    errors++;
                    $display("[TB] FAIL model_any t=%0t got %b want %b", $time, any_tick, exp_any);
                end
            end
            @(posedge clk);
            if (run) prev_lvl = rst ? lvl : '0;
        end
    end

    task automatic applyStimulus(input logic rst_v, input logic [WIDTH-1:0] lvl_v);
        @(negedge clk);
        rst = rst_v;
        lvl = lvl_v;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_edge,
                               input logic [WIDTH-1:0] exp_fall, input logic exp_any);
        #4;
        checks++;
        if (edge_tick !== exp_edge || fall_tick !== exp_fall || any_tick !== exp_any) begin
            errors++;
            $display("[TB] FAIL %s got edge=%b fall=%b any=%b want edge=%b fall=%b any=%b",
                     name, edge_tick, fall_tick, any_tick, exp_edge, exp_fall, exp_any);
        end
    endtask

    initial begin
        rst = 1'b0;
        lvl = '0;
        run = 1'b1;

        // Reset with lane 0 high: masked, then one edge after release
        applyStimulus(1'b0, 4'b0001); checkOutput("rst_mask0", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001); checkOutput("rst_mask1", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0001); checkOutput("rel_edge",  4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0001); checkOutput("rel_hold",  4'b0000, 4'b0000, 1'b0);

        // Sustained high after a low stretch
        applyStimulus(1'b0, 4'b0000); checkOutput("rst_nofall", 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'b0000); checkOutput("low_idle", 4'b0000, 4'b0000, 1'b0);
        end
        applyStimulus(1'b1, 4'b0001); checkOutput("rise", 4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0001); checkOutput("high_hold", 4'b0000, 4'b0000, 1'b0);
        end
        applyStimulus(1'b1, 4'b0000); checkOutput("drop",      4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b1, 4'b0000); checkOutput("drop_hold", 4'b0000, 4'b0000, 1'b0);

        // One-cycle pulse
        applyStimulus(1'b1, 4'b0001); checkOutput("pulse_hi", 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000); checkOutput("pulse_lo", 4'b0000, 4'b0001, 1'b1);

        // Low gap 1,0,0,1
        applyStimulus(1'b1, 4'b0001); checkOutput("gap_1", 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000); checkOutput("gap_2", 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b1, 4'b0000); checkOutput("gap_3", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0001); checkOutput("gap_4", 4'b0001, 4'b0000, 1'b1);

        // Reset mid-operation from state ONE
        applyStimulus(1'b1, 4'b0001); checkOutput("mid_one",  4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000); checkOutput("mid_rst",  4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0000); checkOutput("mid_after", 4'b0000, 4'b0000, 1'b0);
        end

        // Multi-lane independence
        applyStimulus(1'b1, 4'b0101); checkOutput("ml_rise",  4'b0101, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0011); checkOutput("ml_mix",   4'b0010, 4'b0100, 1'b1);
        applyStimulus(1'b1, 4'b0011); checkOutput("ml_hold",  4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b1111); checkOutput("ml_all",   4'b1100, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000); checkOutput("ml_fall",  4'b0000, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b1010); checkOutput("ml_mask",  4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b1010); checkOutput("ml_rel",   4'b1010, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b1000); checkOutput("ml_one",   4'b0000, 4'b0010, 1'b1);

        @(negedge clk);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
